// File: rtl/host_mem_wr_arbiter.sv
// Round-robin write arbiter sharing one host-memory Avalon write channel
// between NUM_REQ burst masters. Grants are held for a whole burst, and
// a small ordered FIFO of requester IDs steers each host write response
// back to the requester whose burst it completes.
module host_mem_wr_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 48,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 6,
    parameter int RESP_FIFO_DEPTH = 64
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_REQ-1:0]                    s_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         s_address,
    input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0]    s_burstcount,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         s_writedata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     s_byteenable,
    output logic [NUM_REQ-1:0]                    s_waitrequest,
    output logic [NUM_REQ-1:0]                    s_writeresponsevalid,
    output logic                                  m_write,
    output logic [ADDR_WIDTH-1:0]                 m_address,
    output logic [BURST_CNT_WIDTH-1:0]            m_burstcount,
    output logic [DATA_WIDTH-1:0]                 m_writedata,
    output logic [DATA_WIDTH/8-1:0]               m_byteenable,
    input  logic                                  m_waitrequest,
    input  logic                                  m_writeresponsevalid,
    output logic [1:0]                            err_sticky
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int SEL_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W    = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam int OCC_W    = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [SEL_W-1:0]            sel_q, sel_d;
    logic [SEL_W-1:0]            last_grant_q, last_grant_d;
    logic [BURST_CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                        first_beat_q, first_beat_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]            occ_q, occ_d;
    logic [1:0]                  err_q, err_d;
    logic [SEL_W-1:0]            fifo_mem_q [RESP_FIFO_DEPTH];

    logic                        pick_valid_s;
    logic [SEL_W-1:0]            pick_idx_s;
    logic                        sel_write_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic                        beat_acc_s;
    logic                        last_beat_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        underflow_s;
    logic [SEL_W-1:0]            head_s;

    assign fifo_full_s  = (occ_q == OCC_W'(RESP_FIFO_DEPTH));
    assign fifo_empty_s = (occ_q == {OCC_W{1'b0}});
    assign head_s       = fifo_mem_q[rd_ptr_q];
    assign beat_acc_s   = m_write & ~m_waitrequest;
    assign push_s       = beat_acc_s & first_beat_q;
    assign pop_s        = m_writeresponsevalid & ~fifo_empty_s;
    assign underflow_s  = m_writeresponsevalid & fifo_empty_s;
    assign last_beat_s  = first_beat_q ? (m_burstcount <= BURST_CNT_WIDTH'(1'b1))
                                       : (beat_cnt_q == BURST_CNT_WIDTH'(1'b1));
    assign err_sticky   = err_q;

    // Round-robin pick: scan from last_grant+1; the nearest active requester wins.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = {SEL_W{1'b0}};
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx          = (int'(last_grant_q) + k) % NUM_REQ;
            pick_valid_s = pick_valid_s | s_write[idx];
            pick_idx_s   = s_write[idx] ? SEL_W'(idx) : pick_idx_s;
        end
    end

    // Forward the selected requester's command and data onto the host channel.
    always_comb begin
        sel_write_s  = 1'b0;
        m_address    = {ADDR_WIDTH{1'b0}};
        m_burstcount = {BURST_CNT_WIDTH{1'b0}};
        m_writedata  = {DATA_WIDTH{1'b0}};
        m_byteenable = {BE_WIDTH{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_write_s  = s_write[i];
                m_address    = s_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_burstcount = s_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
                m_writedata  = s_writedata[i*DATA_WIDTH +: DATA_WIDTH];
                m_byteenable = s_byteenable[i*BE_WIDTH +: BE_WIDTH];
            end else begin
                sel_write_s  = sel_write_s;
            end
        end
    end

    // Handshake outputs: only the granted requester sees host backpressure; responses follow the FIFO head.
    always_comb begin
        m_write = (state_q == ST_BURST) & sel_write_s;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state_q == ST_BURST) && (sel_q == SEL_W'(i))) begin
                s_waitrequest[i] = m_waitrequest;
            end else begin
                s_waitrequest[i] = 1'b1;
            end
            s_writeresponsevalid[i] = pop_s & (head_s == SEL_W'(i));
        end
    end

    // Grant FSM next state: arbitrate in IDLE, hold the grant until the last beat of the burst is accepted.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        first_beat_d = first_beat_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s && !fifo_full_s) begin
                    sel_d        = pick_idx_s;
                    state_d      = ST_BURST;
                    first_beat_d = 1'b1;
                    beat_cnt_d   = {BURST_CNT_WIDTH{1'b0}};
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (beat_acc_s) begin
                    if (last_beat_s) begin
                        last_grant_d = sel_q;
                        state_d      = ST_IDLE;
                        beat_cnt_d   = {BURST_CNT_WIDTH{1'b0}};
                        first_beat_d = 1'b0;
                    end else if (first_beat_q) begin
                        beat_cnt_d   = m_burstcount - BURST_CNT_WIDTH'(1'b1);
                        first_beat_d = 1'b0;
                    end else begin
                        beat_cnt_d   = beat_cnt_q - BURST_CNT_WIDTH'(1'b1);
                    end
                end else begin
                    state_d = ST_BURST;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                first_beat_d = 1'b0;
            end
        endcase
    end

    // Response FIFO bookkeeping and sticky error flags; a zero burstcount counts as one beat.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q | {underflow_s, push_s & (m_burstcount == {BURST_CNT_WIDTH{1'b0}})};
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1'b1);
            2'b01:   occ_d = occ_q - OCC_W'(1'b1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state registers; reset drops any partial burst and all outstanding responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= {SEL_W{1'b0}};
            last_grant_q <= SEL_W'(NUM_REQ - 1);
            beat_cnt_q   <= {BURST_CNT_WIDTH{1'b0}};
            first_beat_q <= 1'b0;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            occ_q        <= {OCC_W{1'b0}};
            err_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            first_beat_q <= first_beat_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            err_q        <= err_d;
        end
    end

    // Response FIFO storage: record the granted requester on the first accepted beat of each burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= {SEL_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= sel_q;
        end else begin
            fifo_mem_q[wr_ptr_q] <= fifo_mem_q[wr_ptr_q];
        end
    end

endmodule

// File: doc/host_mem_wr_arbiter.md
HOST_MEM_WR_ARBITER -- requirements
Module: host_mem_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of write requesters sharing the host-memory Avalon write channel.
REQ-002 Parameter ADDR_WIDTH, default 48: byte address width.
REQ-003 Parameter DATA_WIDTH, default 512: data width; byteenable width is DATA_WIDTH/8.
REQ-004 Parameter BURST_CNT_WIDTH, default 6: burstcount width.
REQ-005 Parameter RESP_FIFO_DEPTH, default 64, power of two: maximum number of outstanding write bursts.
REQ-006 Port clk, input, 1: single clock for all logic.
REQ-007 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-008 Ports s_write / s_address / s_burstcount / s_writedata / s_byteenable, input, NUM_REQ x {1, ADDR_WIDTH, BURST_CNT_WIDTH, DATA_WIDTH, DATA_WIDTH/8}: per-requester write command and data, flattened with requester 0 in the LSBs.
REQ-009 Port s_waitrequest, output, NUM_REQ: per-requester backpressure.
REQ-010 Port s_writeresponsevalid, output, NUM_REQ: per-requester write-response pulse.
REQ-011 Ports m_write / m_address / m_burstcount / m_writedata / m_byteenable, output, widths as REQ-008 for a single channel: shared host write channel.
REQ-012 Port m_waitrequest, input, 1: host channel backpressure.
REQ-013 Port m_writeresponsevalid, input, 1: one pulse per completed burst, in issue order.
REQ-014 Port err_sticky, output, 2: bit0 = zero burstcount seen; bit1 = response received with no outstanding burst.

Function
REQ-015 The FSM SHALL have two states. IDLE is the reset state. BURST is entered when a grant has been made.
REQ-016 In IDLE, the block SHALL select the next requester with s_write=1 in round-robin order, starting at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1.
- The selection SHALL be registered into sel, and the FSM SHALL enter BURST on the next edge.
- Arbitration latency is therefore 1 cycle.
REQ-017 The block SHALL NOT leave IDLE while the response FIFO is full.
REQ-018 In IDLE, all s_waitrequest SHALL be 1 and m_write SHALL be 0.
REQ-019 In BURST, the m_* command and data signals SHALL be driven combinationally from requester sel.
- s_waitrequest[sel] SHALL equal m_waitrequest.
- All other s_waitrequest bits SHALL be 1.
REQ-020 A beat is accepted when m_write=1 and m_waitrequest=0.
- On the first accepted beat of a burst, the beat counter SHALL load m_burstcount-1.
- A burstcount of 0 SHALL be treated as 1 and SHALL set err_sticky[0].
- Each later accepted beat SHALL decrement the counter.
REQ-021 m_burstcount and m_address SHALL be forwarded unchanged on every beat; the block imposes no address-increment rule.
REQ-022 When the last beat is accepted, the block SHALL:
- update last_grant to sel;
- return to IDLE.
One idle bubble cycle between bursts is required behaviour.
REQ-023 If the selected requester deasserts s_write mid-burst, the block SHALL stay in BURST and hold the grant until all beats are accepted; there is no timeout.
REQ-024 On the first accepted beat of each burst, the block SHALL push sel into a FIFO of RESP_FIFO_DEPTH entries.
REQ-025 On m_writeresponsevalid=1, the block SHALL:
- pop the FIFO head;
- pulse s_writeresponsevalid[head] for exactly 1 cycle, in the same cycle (combinational from the head).
REQ-026 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-027 A pop when the FIFO is empty SHALL:
- drive no s_writeresponsevalid;
- set err_sticky[1];
- leave the occupancy at 0.
REQ-028 FIFO pointers SHALL wrap modulo RESP_FIFO_DEPTH. Occupancy SHALL be tracked with log2(RESP_FIFO_DEPTH)+1 bits, so that full and empty are distinct.

Reset
REQ-029 On reset_n low, the block SHALL take the following values asynchronously:
- FSM = IDLE, sel = 0, last_grant = NUM_REQ-1;
- beat counter = 0, FIFO pointers and occupancy = 0, err_sticky = 0;
- m_write = 0, s_writeresponsevalid = 0, all s_waitrequest = 1.
REQ-030 A reset in mid-burst SHALL discard the partial burst and all outstanding-response state; recovery is the caller's responsibility.
REQ-031 Reset release SHALL be synchronous to clk; the first arbitration occurs on the first edge with reset_n high.

Verification
REQ-032 Both requesters assert 4-beat bursts continuously, m_waitrequest=0 -> grants alternate 0,1,0,1. Each burst occupies 4 beat cycles plus 1 idle cycle. No beat interleaving occurs.
REQ-033 Requester 1 is in a burst of 8 and m_waitrequest toggles every cycle -> exactly 8 beats are accepted, and requester 0 stays stalled until requester 1's last beat plus 1 cycle.
REQ-034 Issue 3 bursts (req0, req1, req0), then 3 m_writeresponsevalid pulses -> s_writeresponsevalid pulses go to 0, 1, 0 in order.
REQ-035 Hold m_writeresponsevalid=0 with RESP_FIFO_DEPTH=4 and issue single-beat writes -> exactly 4 bursts are issued, then the FSM stalls in IDLE. One response pulse -> exactly 1 further burst is issued.
REQ-036 Apply burstcount=0 -> 1 beat is issued and err_sticky=01. Apply m_writeresponsevalid with the FIFO empty -> err_sticky=11.
REQ-037 Assert reset_n=0 on the 2nd beat of a 4-beat burst -> m_write=0 and all s_waitrequest=1 in the same cycle. After release, requester 0 wins first.
